uart_status_tx: RTL
===================

# uart_status_tx

Reports the generator's live settings back to the host over the serial link. It is the transmit-side counterpart of the UART command path that sets frequency, amplitude and phase. On a `report` pulse it snapshots `state_freq`, `state_amp` and `state_phase` and converts them to fixed-width decimal ASCII. It then serialises the 20-byte status line, 8N1, on `tx`. It sits beside the command decoder and drives the board's UART TX pin directly.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock in Hz.
- `BAUD`, default 115200: line rate.
- `BAUD_DIV`, default `(CLK_FREQ + BAUD/2) / BAUD` (434): clocks per bit. Values below 2 are illegal.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `report`  in  1  request pulse. Sampled on each rising edge; ignored while `busy`.
- `state_freq`  in  12  frequency setting, 0..4095.
- `state_amp`  in  8  amplitude setting, 0..255.
- `state_phase`  in  8  phase setting, 0..255.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from request acceptance until the line completes.
- `done`  out  1  one-cycle pulse when the last stop bit finishes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, FSM in IDLE, all counters 0.
- Message format is `F=dddd A=ddd P=ddd` followed by CR LF, 20 bytes total.
  - Fields are zero-padded decimal: freq 4 digits, amp 3, phase 3.
  - Example: 524/50/50 gives `F=0524 A=050 P=050`.
- FSM states:
  - IDLE: `report`=1 snapshots all three inputs, sets `busy`, and goes to CONV.
  - CONV: 12-iteration double-dabble, one shift per cycle. The amp and phase registers are zero-extended to 12 bits and converted in parallel. Goes to SEND.
  - SEND: byte index 0..19. Each byte is framed as start(0), d0..d7 LSB first, stop(1). The next byte's start bit follows the previous stop bit with no gap. After byte 19 goes to DONE.
  - DONE: pulses `done`, clears `busy`, returns to IDLE.
- Digit to ASCII: `8'h30 + digit`. The constant bytes come from a ROM indexed by byte index: `F`=0x46, `=`=0x3D, space=0x20, `A`=0x41, `P`=0x50, CR=0x0D, LF=0x0A.
- Input changes after the snapshot never affect the line in progress.
- `report` while `busy` is dropped, not queued. `report` in the same cycle as `done` is also dropped.
- Reset mid-line: `tx` goes high asynchronously and the partial byte is abandoned. There is no `done` pulse.

## Timing
- E0 is the edge that samples `report`=1. `busy`=1 after E0.
- CONV occupies E1..E12. The start bit of byte 0 is driven from E13.
- Each bit holds for exactly `BAUD_DIV` cycles. A frame is 10 bits (11 with parity).
- At E13 + 20·frame·BAUD_DIV: `done`=1 for one cycle, `busy`=0, `tx` stays high.
- Default total: 13 + 200·434 = 86813 cycles from E0 to the `done` edge.
- A new `report` is accepted on the cycle after `done`.

## Configuration
- `UART_STATUS_TX_PARITY_EN` defined: an even-parity bit is inserted after d7 (8E1). The frame is 11 bits and the total becomes 13 + 220·BAUD_DIV.
- Undefined: 8N1, with no parity logic.

## Structure
- Shared package holds:
  - Message constants: `MSG_LEN`=20 and the constant-byte ROM contents.
  - The ASCII zero offset.
  - The FSM state enum (IDLE/CONV/SEND/DONE).
- Sub-module `uart_tx_byte` handles the baud counter and bit serialiser.
  - Handshake: `start`/`data[7:0]` in, `tx`/`ready` out. `ready` pulses on the final stop-bit cycle so the next byte can start back-to-back.
  - The parity option lives inside it.
- The top level holds the snapshot registers, double-dabble, byte mux and FSM.

## Test plan
- Reset, then idle 1000 cycles: `tx`=1, `busy`=0, `done` never pulses.
- freq=524, amp=50, phase=50, `report` pulse: decoded bytes are `F=0524 A=050 P=050` CR LF. `done` arrives at exactly E0+86813.
- freq=4095, amp=255, phase=0: `F=4095 A=255 P=000` CR LF. freq=0: `F=0000`.
- `report` re-pulsed at E0+5000, and inputs changed mid-line: output is unchanged and there is a single `done`.
- `rst` asserted at E0+3000: `tx`=1 immediately and `busy`=0. A new `report` then yields a clean full line.
- With `UART_STATUS_TX_PARITY_EN` defined and freq=1, amp=0, phase=0: each frame is 11 bits with even parity correct on all 20 bytes. `done` arrives at E0+13+220·434.

Source files
------------

// File: rtl/uart_status_tx_pkg.sv
// Shared constants, state encoding and helpers for the status-line transmitter.
package uart_status_tx_pkg;

    localparam int MSG_LEN = 20;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fixed characters of "F=dddd A=ddd P=ddd\r\n"; digit positions read as zero.
    function automatic logic [7:0] const_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:                b = 8'h46;
            5'd1, 5'd8, 5'd14:   b = 8'h3D;
            5'd6, 5'd12:         b = 8'h20;
            5'd7:                b = 8'h41;
            5'd13:               b = 8'h50;
            5'd18:               b = 8'h0D;
            5'd19:               b = 8'h0A;
            default:             b = 8'h00;
        endcase
        return b;
    endfunction

    // One double-dabble iteration on {bcd[15:0], bin[11:0]}: add-3 correction then shift.
    function automatic logic [27:0] dabble_step(input logic [27:0] v);
        logic [27:0] t;
        t = v;
        for (int d = 0; d < 4; d++) begin
            if (t[12 + 4*d +: 4] >= 4'd5) begin
                t[12 + 4*d +: 4] = t[12 + 4*d +: 4] + 4'd3;
            end else begin
                t[12 + 4*d +: 4] = t[12 + 4*d +: 4];
            end
        end
        return {t[26:0], 1'b0};
    endfunction

endpackage

// File: rtl/uart_status_tx_tx_byte.sv
// Single-byte UART serialiser with baud counter; back-to-back frames via ready.
// UART_STATUS_TX_PARITY_EN selects 8E1 framing, otherwise 8N1.
module uart_tx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

`ifdef UART_STATUS_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    logic          active_r;
    logic [3:0]    bit_r;
    logic [CW-1:0] baud_r;
    logic [7:0]    data_r;
    logic          tx_r;
    logic          bit_end_s;
    logic          next_bit_s;
    logic [3:0]    bit_nx_s;

    assign bit_end_s = active_r && (baud_r == BAUD_LAST);
    assign ready     = bit_end_s && (bit_r == LAST_BIT);
    assign tx        = tx_r;

    // Value of the line for the bit that follows the current one.
    always_comb begin
        bit_nx_s   = bit_r + 4'd1;
        next_bit_s = 1'b1;
        if (bit_nx_s == LAST_BIT) begin
            next_bit_s = 1'b1;
`ifdef UART_STATUS_TX_PARITY_EN
        end else if (bit_nx_s == 4'd9) begin
            next_bit_s = ^data_r;
`endif
        end else begin
            next_bit_s = data_r[bit_nx_s[2:0] - 3'd1];
        end
    end

    // Frame sequencing; the line is left at stop level between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= 1'b0;
            bit_r    <= 4'd0;
            baud_r   <= '0;
            data_r   <= 8'd0;
            tx_r     <= 1'b1;
        end else if (start) begin
            active_r <= 1'b1;
            bit_r    <= 4'd0;
            baud_r   <= '0;
            data_r   <= data;
            tx_r     <= 1'b0;
        end else if (bit_end_s) begin
            baud_r <= '0;
            if (bit_r == LAST_BIT) begin
                active_r <= 1'b0;
            end else begin
                bit_r <= bit_nx_s;
                tx_r  <= next_bit_s;
            end
        end else if (active_r) begin
            baud_r <= baud_r + CW'(1);
        end
    end

endmodule

// File: rtl/uart_status_tx.sv
// Snapshots freq/amp/phase on report and transmits "F=dddd A=ddd P=ddd\r\n".
// Define UART_STATUS_TX_PARITY_EN for even-parity (8E1) frames.
module uart_status_tx
    import uart_status_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        report,
    input  logic [11:0] state_freq,
    input  logic [7:0]  state_amp,
    input  logic [7:0]  state_phase,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    state_t      state_r, state_nx_s;
    logic [15:0] f_bcd_r, a_bcd_r, p_bcd_r;
    logic [11:0] f_bin_r, a_bin_r, p_bin_r;
    logic [3:0]  conv_r;
    logic [4:0]  idx_r;
    logic        first_r, busy_r, done_r;
    logic        start_s, ready_s, digit_pos_s;
    logic [3:0]  digit_s;
    logic [7:0]  byte_s;

    assign busy = busy_r;
    assign done = done_r;

    // Next state and byte-launch request.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        case (state_r)
            IDLE: if (report) state_nx_s = CONV; else state_nx_s = IDLE;
            CONV: if (conv_r == 4'd11) state_nx_s = SEND; else state_nx_s = CONV;
            SEND: begin
                if (ready_s && (idx_r == 5'(MSG_LEN))) begin
                    state_nx_s = DONE;
                end else if (first_r || ready_s) begin
                    start_s = 1'b1;
                end else begin
                    state_nx_s = SEND;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Byte mux: BCD digit as ASCII at digit positions, ROM constant elsewhere.
    always_comb begin
        digit_s     = 4'd0;
        digit_pos_s = 1'b1;
        case (idx_r)
            5'd2:    digit_s = f_bcd_r[15:12];
            5'd3:    digit_s = f_bcd_r[11:8];
            5'd4:    digit_s = f_bcd_r[7:4];
            5'd5:    digit_s = f_bcd_r[3:0];
            5'd9:    digit_s = a_bcd_r[11:8];
            5'd10:   digit_s = a_bcd_r[7:4];
            5'd11:   digit_s = a_bcd_r[3:0];
            5'd15:   digit_s = p_bcd_r[11:8];
            5'd16:   digit_s = p_bcd_r[7:4];
            5'd17:   digit_s = p_bcd_r[3:0];
            default: digit_pos_s = 1'b0;
        endcase
        if (digit_pos_s) begin
            byte_s = ASCII_ZERO + {4'd0, digit_s};
        end else begin
            byte_s = const_byte(idx_r);
        end
    end

    // State register, snapshot, conversion and line sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            f_bcd_r <= 16'd0;
            a_bcd_r <= 16'd0;
            p_bcd_r <= 16'd0;
            f_bin_r <= 12'd0;
            a_bin_r <= 12'd0;
            p_bin_r <= 12'd0;
            conv_r  <= 4'd0;
            idx_r   <= 5'd0;
            first_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            done_r  <= (state_r == SEND) && (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (report) begin
                        f_bin_r <= state_freq;
                        a_bin_r <= {4'd0, state_amp};
                        p_bin_r <= {4'd0, state_phase};
                        f_bcd_r <= 16'd0;
                        a_bcd_r <= 16'd0;
                        p_bcd_r <= 16'd0;
                        conv_r  <= 4'd0;
                        busy_r  <= 1'b1;
                    end
                end
                CONV: begin
                    {f_bcd_r, f_bin_r} <= dabble_step({f_bcd_r, f_bin_r});
                    {a_bcd_r, a_bin_r} <= dabble_step({a_bcd_r, a_bin_r});
                    {p_bcd_r, p_bin_r} <= dabble_step({p_bcd_r, p_bin_r});
                    conv_r <= conv_r + 4'd1;
                    if (conv_r == 4'd11) begin
                        first_r <= 1'b1;
                        idx_r   <= 5'd0;
                    end
                end
                SEND: begin
                    if (start_s) begin
                        idx_r   <= idx_r + 5'd1;
                        first_r <= 1'b0;
                    end
                    if (state_nx_s == DONE) begin
                        busy_r <= 1'b0;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .data  (byte_s),
        .tx    (tx),
        .ready (ready_s)
    );

endmodule
